// File: rtl/log2_pipe.sv
// Three-stage pipelined log2 approximator with valid/ready handshake, tag and zero flag.
// Define LOG2_PIPE_ROUND_EN for round-to-nearest fractions; default truncates.
module log2_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int FRAC_BITS = 3,
  parameter int TAG_WIDTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [IN_WIDTH-1:0]   log_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [$clog2(IN_WIDTH)+FRAC_BITS-1:0] log_out,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  zero_out
);

  localparam int IDX_WIDTH = $clog2(IN_WIDTH);
  localparam int OUT_WIDTH = IDX_WIDTH + FRAC_BITS;
  localparam int PW        = 1 << IDX_WIDTH;
  localparam int EW        = IN_WIDTH + FRAC_BITS + 1;

  logic                 rdy_q;
  logic                 s1_v, s2_v, s3_v;
  logic                 s1_ld, s2_ld, s3_ld, acc;
  logic [IN_WIDTH-1:0]  s1_op, s2_op;
  logic [TAG_WIDTH-1:0] s1_tag, s2_tag;
  logic [IDX_WIDTH-1:0] s2_idx, idx_c;
  logic                 s2_zero;
  logic [PW-1:0]        srch;
  logic [IDX_WIDTH-1:0] sh;
  logic [EW-1:0]        ext;
  logic [FRAC_BITS-1:0] frac;
  logic [OUT_WIDTH-1:0] res;
  logic                 unused_ext;

  assign s3_ld        = !s3_v || out_ready_in;
  assign s2_ld        = !s2_v || s3_ld;
  assign s1_ld        = !s1_v || s2_ld;
  assign in_ready_out = rdy_q && s1_ld;
  assign acc          = in_valid_in && in_ready_out;
  assign out_valid_out = s3_v;

  // Halving search: each step tests whether the upper half of the window is non-zero.
  always_comb begin
    srch  = PW'(s1_op);
    idx_c = '0;
    for (int k = IDX_WIDTH - 1; k >= 0; k--) begin
      if (|(srch >> (1 << k))) begin
        idx_c = idx_c | IDX_WIDTH'(1 << k);
        srch  = srch >> (1 << k);
      end
    end
  end

  // Normalise so the leading one lands at the top; fraction and guard follow it.
  always_comb begin
    sh   = IDX_WIDTH'(IN_WIDTH - 1) - s2_idx;
    ext  = {s2_op, {(FRAC_BITS + 1){1'b0}}} << sh;
    frac = ext[EW-2 -: FRAC_BITS];
`ifdef LOG2_PIPE_ROUND_EN
    if (ext[EW-2-FRAC_BITS] && (&frac) &&
        s2_idx == IDX_WIDTH'(IN_WIDTH - 1))
      res = '1;
    else
      res = {s2_idx, frac} + OUT_WIDTH'(ext[EW-2-FRAC_BITS]);
`else
    res = {s2_idx, frac};
`endif
  end

  assign unused_ext = ^ext;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_q    <= 1'b0;
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s3_v     <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s2_op    <= '0;
      s2_tag   <= '0;
      s2_idx   <= '0;
      s2_zero  <= 1'b0;
      log_out  <= '0;
      tag_out  <= '0;
      zero_out <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_ld) s1_v <= acc;
      if (acc) begin
        s1_op  <= log_in;
        s1_tag <= tag_in;
      end
      if (s2_ld) s2_v <= s1_v;
      if (s1_v && s2_ld) begin
        s2_op   <= s1_op;
        s2_tag  <= s1_tag;
        s2_idx  <= idx_c;
        s2_zero <= (s1_op == '0);
      end
      if (s3_ld) s3_v <= s2_v;
      if (s2_v && s3_ld) begin
        log_out  <= res;
        tag_out  <= s2_tag;
        zero_out <= s2_zero;
      end
    end
  end

endmodule

// File: tb/tb_log2_pipe.sv
// Self-checking bench for log2_pipe: directed cases, backpressure,
// randomized handshake against a queue-based arithmetic model, and mid-stream reset.
module tb_log2_pipe;

  localparam int IN_W  = 32;
  localparam int FB    = 3;
  localparam int TW    = 4;
  localparam int OUT_W = $clog2(IN_W) + FB;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             in_valid_in;
  logic             in_ready_out;
  logic [IN_W-1:0]  log_in;
  logic [TW-1:0]    tag_in;
  logic             out_valid_out;
  logic             out_ready_in;
  logic [OUT_W-1:0] log_out;
  logic [TW-1:0]    tag_out;
  logic             zero_out;

  always #5 clk_in = ~clk_in;

  log2_pipe #(
    .IN_WIDTH (IN_W),
    .FRAC_BITS(FB),
    .TAG_WIDTH(TW)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .in_valid_in  (in_valid_in),
    .in_ready_out (in_ready_out),
    .log_in       (log_in),
    .tag_in       (tag_in),
    .out_valid_out(out_valid_out),
    .out_ready_in (out_ready_in),
    .log_out      (log_out),
    .tag_out      (tag_out),
    .zero_out     (zero_out)
  );

  typedef struct packed {
    logic [OUT_W-1:0] lg;
    logic [TW-1:0]    tg;
    logic             z;
  } beat_t;

  beat_t q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    hold_v = 0;
  beat_t hold_b;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic model: log2 value scaled by 2^FB from integer shifts.
  function automatic logic [OUT_W-1:0] ref_log(input logic [IN_W-1:0] x);
    int     idx;
    longint f, v;
    if (x == 0) return '0;
    idx = 0;
    for (int i = 0; i < IN_W; i++) if (x[i]) idx = i;
    f = ((longint'(x) << FB) >> idx) - (longint'(1) << FB);
    v = longint'(idx) * (longint'(1) << FB) + f;
`ifdef LOG2_PIPE_ROUND_EN
    v = v + (((longint'(x) << (FB + 1)) >> idx) & 1);
    if (v > longint'(IN_W) * (longint'(1) << FB) - 1)
      v = (longint'(1) << OUT_W) - 1;
`endif
    return OUT_W'(v);
  endfunction

  function automatic logic [IN_W-1:0] rand_op();
    logic [IN_W-1:0] r;
    case ($urandom_range(0, 5))
      0: r = '0;
      1: r = 1;
      2: r = IN_W'(1) << $urandom_range(0, IN_W - 1);
      3: r = '1;
      4: r = $urandom;
      default: r = $urandom >> $urandom_range(0, IN_W - 1);
    endcase
    return r;
  endfunction

  task automatic step(output bit a, output bit m);
    beat_t e;
    @(negedge clk_in);
    a = in_valid_in && in_ready_out;
    m = out_valid_out && out_ready_in;
    if (hold_v) begin
      chk("hold_log", log_out, hold_b.lg);
      chk("hold_tag", tag_out, hold_b.tg);
      chk("hold_zero", zero_out, hold_b.z);
    end
    hold_v = out_valid_out && !out_ready_in;
    hold_b = '{log_out, tag_out, zero_out};
    if (m) begin
      if (q.size() == 0) chk("spurious", 1, 0);
      else begin
        e = q.pop_front();
        chk("log", log_out, e.lg);
        chk("tag", tag_out, e.tg);
        chk("zero", zero_out, e.z);
      end
    end
    if (a) q.push_back('{ref_log(log_in), tag_in, log_in == 0});
    @(posedge clk_in);
    #1;
  endtask

  task automatic run1(input logic [IN_W-1:0] x, input logic [TW-1:0] t,
                      input logic [OUT_W-1:0] e, input logic ez);
    bit a, m;
    in_valid_in  = 1'b1;
    log_in       = x;
    tag_in       = t;
    out_ready_in = 1'b1;
    step(a, m);
    chk("d_acc", a, 1);
    in_valid_in = 1'b0;
    chk("d_lat0", out_valid_out, 0);
    step(a, m);
    chk("d_lat1", out_valid_out, 0);
    step(a, m);
    chk("d_valid", out_valid_out, 1);
    chk("d_log", log_out, e);
    chk("d_tag", tag_out, t);
    chk("d_zero", zero_out, ez);
    step(a, m);
    chk("d_emit", m, 1);
  endtask

  initial begin
    bit a, m;
    int nxt, emitted, cyc, sent, got;
    rst_n_in     = 1'b0;
    in_valid_in  = 1'b0;
    log_in       = '0;
    tag_in       = '0;
    out_ready_in = 1'b0;
    #12;
    chk("rst_ovalid", out_valid_out, 0);
    chk("rst_irdy", in_ready_out, 0);
    chk("rst_log", log_out, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_zero", zero_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("rdy_after_rst", in_ready_out, 1);

    run1(32'd0, 4'd1, 8'h00, 1'b1);
    run1(32'd1, 4'd2, 8'h00, 1'b0);
    run1(32'd12, 4'd3, 8'h1C, 1'b0);
    run1(32'h8000_0000, 4'd4, 8'hF8, 1'b0);
`ifdef LOG2_PIPE_ROUND_EN
    run1(32'd31, 4'd5, 8'h28, 1'b0);
    run1(32'hFFFF_FFFF, 4'd6, 8'hFF, 1'b0);
    run1(32'd15, 4'd7, 8'h1F, 1'b0);
`else
    run1(32'd31, 4'd5, 8'h27, 1'b0);
    run1(32'hFFFF_FFFF, 4'd6, 8'hFF, 1'b0);
    run1(32'd15, 4'd7, 8'h1F, 1'b0);
`endif

    // Backpressure: fill with downstream stalled, then drain.
    out_ready_in = 1'b0;
    nxt = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid_in = 1'b1;
      tag_in      = TW'(nxt);
      log_in      = IN_W'(nxt * 100);
      step(a, m);
      if (a) nxt++;
    end
    chk("bp_accepted", nxt - 1, 3);
    chk("bp_irdy", in_ready_out, 0);
    chk("bp_ovalid", out_valid_out, 1);
    chk("bp_tag", tag_out, 1);
    chk("bp_log", log_out, ref_log(100));
    out_ready_in = 1'b1;
    emitted = 0;
    cyc = 0;
    while (emitted < 5 && cyc < 12) begin
      if (nxt <= 5) begin
        in_valid_in = 1'b1;
        tag_in      = TW'(nxt);
        log_in      = IN_W'(nxt * 100);
      end else in_valid_in = 1'b0;
      step(a, m);
      if (a) nxt++;
      if (m) emitted++;
      cyc++;
    end
    in_valid_in = 1'b0;
    chk("bp_emitted", emitted, 5);
    chk("bp_cycles", cyc, 5);
    chk("bp_empty", q.size(), 0);

    // Randomized traffic with random downstream stalls.
    sent = 0;
    got  = 0;
    a    = 0;
    for (cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      out_ready_in = 1'($urandom_range(0, 1));
      if (!in_valid_in || a) begin
        if (sent < 1000 && $urandom_range(0, 1) == 1) begin
          in_valid_in = 1'b1;
          log_in      = rand_op();
          tag_in      = TW'($urandom);
        end else in_valid_in = 1'b0;
      end
      step(a, m);
      if (a) sent++;
      if (m) got++;
    end
    in_valid_in = 1'b0;
    chk("rand_done", got, 1000);
    chk("rand_empty", q.size(), 0);

    // Reset with two beats in flight.
    out_ready_in = 1'b0;
    in_valid_in  = 1'b1;
    log_in       = 32'd5;
    tag_in       = 4'd9;
    step(a, m);
    log_in = 32'd6;
    tag_in = 4'd10;
    step(a, m);
    in_valid_in = 1'b0;
    step(a, m);
    chk("pre_rst_ovalid", out_valid_out, 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_ovalid", out_valid_out, 0);
    chk("mid_rst_log", log_out, 0);
    chk("mid_rst_irdy", in_ready_out, 0);
    q.delete();
    hold_v = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in     = 1'b1;
    out_ready_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(a, m);
      chk("post_rst_quiet", out_valid_out, 0);
    end
    chk("post_rst_irdy", in_ready_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
